// File: rtl/cereal_rx.sv
// cereal_rx: 8N1 serial receiver (idle high, LSB first) with a buffered byte output.
// Define CEREAL_RX_FIFO_EN for a DEPTH-entry FIFO; the default build uses a single holding register.
//
// state   | meaning
// --------+---------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on rx_s
// S_START | timing to mid start bit to confirm it is real
// S_DATA  | sampling 8 data bits at mid-bit, LSB first
// S_STOP  | sampling stop bit at mid-bit, then push or flag
module cereal_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DEPTH        = 8
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("cereal_rx: CLKS_PER_BIT must be >= 4 and DEPTH a power of 2 >= 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_meta_q, rx_s_q;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          push, pop, accept, ovr_set;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Bit timer is a down-counter: loaded on each phase entry, phase acts at terminal count 0.
    always_comb begin
        state_d = state_q;
        cyc_d   = (cyc_q == '0) ? '0 : cyc_q - 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                cyc_d = HALF_TC;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cyc_q == '0) begin
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        cyc_d   = FULL_TC;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cyc_q == '0) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cyc_d   = FULL_TC;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_STOP: begin
                if (cyc_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        push        = (state_q == S_STOP) && (cyc_q == '0) && rx_s_q;
        frame_err_d = (state_q == S_STOP) && (cyc_q == '0) && !rx_s_q;
    end

`ifdef CEREAL_RX_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    data_q, data_d;
    logic          full;

    always_comb begin
        full     = (count_q == (AW + 1)'(DEPTH));
        pop      = rd && (count_q != '0);
        accept   = push && (!full || pop);
        ovr_set  = push && full && !pop;
        count_d  = count_q + (AW + 1)'(accept) - (AW + 1)'(pop);
        wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        // Registered head: when the FIFO drains to empty the last head byte is held.
        if (count_d == '0)                      data_d = data_q;
        else if (count_q == (AW + 1)'(pop))     data_d = shift_q;
        else                                    data_d = mem[rd_ptr_d];
    end

    always_ff @(posedge sysclk) begin
        if (accept) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
        end
    end

    assign valid = (count_q != '0);
    assign data  = data_q;
`else
    logic       full_q, full_d;
    logic [7:0] data_q, data_d;

    always_comb begin
        pop     = rd && full_q;
        accept  = push && (!full_q || pop);
        ovr_set = push && full_q && !pop;
        full_d  = accept || (full_q && !pop);
        data_d  = accept ? shift_q : data_q;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign valid = full_q;
    assign data  = data_q;
`endif

    // A new overrun wins over a simultaneous clear.
    assign overrun_d = ovr_set || (overrun_q && !clr_err);
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule
